// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in, serial-out shifter.
//   state_e : IDLE / SHIFT state encoding
//   cnt_w() : width of the bits-remaining counter for a given word width
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Counter width: clog2(width), never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shifter.sv
// Parallel-in, serial-out shifter. Accepts a WIDTH-bit word on a valid/ready
// handshake and emits it one bit per enabled clock, back-to-back words
// streaming with no idle bit between them.
//   clk, rst   : clock, synchronous active-high reset
//   din_valid  : producer has a word on din
//   din        : parallel word, sampled only on the accept cycle
//   din_ready  : block can accept a word this cycle (combinational)
//   en         : serial advance enable; low holds the current bit
//   dout       : serial data bit (registered, 0 when not valid)
//   dout_valid : dout carries a valid bit (registered)
//   last       : current dout is the final bit of its word
//   busy       : a word is in flight (same as dout_valid)
module piso_shifter
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    input  logic             en,
    output logic             dout,
    output logic             dout_valid,
    output logic             last,
    output logic             busy
);

    localparam int unsigned      CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               dout_q,  dout_d;
    logic               valid_q, valid_d;
    logic               accept;

    // Bit that goes out first from a word in the shift register.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Move the next bit into the head position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Ready while idle, or when the final bit is being consumed this cycle.
    assign din_ready  = (state_q == ST_IDLE) ||
                        ((state_q == ST_SHIFT) && (cnt_q == '0) && en);
    assign accept     = din_valid && din_ready;

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign last       = valid_q && (cnt_q == '0);
    assign busy       = valid_q;

    // State, shift register, counter and serial output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    // Next-state: load on accept, advance on en, drop to idle after the last bit.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = valid_q;

        case (state_q)
            ST_IDLE: begin
                dout_d  = 1'b0;
                valid_d = 1'b0;
                if (accept) begin
                    state_d = ST_SHIFT;
                    shreg_d = din;
                    cnt_d   = CNT_LOAD;
                    dout_d  = head_bit(din);
                    valid_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (en) begin
                    if (cnt_q != '0) begin
                        shreg_d = advance(shreg_q);
                        cnt_d   = cnt_q - CNT_W'(1);
                        dout_d  = head_bit(advance(shreg_q));
                    end else if (accept) begin
                        // Reload in the final-bit cycle so the stream has no gap.
                        shreg_d = din;
                        cnt_d   = CNT_LOAD;
                        dout_d  = head_bit(din);
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        shreg_d = '0;
                        cnt_d   = '0;
                        dout_d  = 1'b0;
                        valid_d = 1'b0;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_piso_shifter.sv
// Directed bench for piso_shifter: a cycle table on an MSB-first instance,
// then an LSB-first word captured by a bench-side serial receiver.
module tb_piso_shifter;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid;
    logic [3:0] din;
    logic       en;

    logic m_ready, m_dout, m_valid, m_last, m_busy;
    logic l_ready, l_dout, l_valid, l_last, l_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_shifter #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .din_ready(m_ready), .en(en), .dout(m_dout), .dout_valid(m_valid),
        .last(m_last), .busy(m_busy)
    );

    piso_shifter #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .din_ready(l_ready), .en(en), .dout(l_dout), .dout_valid(l_valid),
        .last(l_last), .busy(l_busy)
    );

    // One clock of stimulus: inputs, din_ready before the edge, outputs after.
    typedef struct {
        logic       rst;
        logic       dv;
        logic       en;
        logic [3:0] din;
        logic       rdy;
        logic       dout;
        logic       vld;
        logic       lst;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic dv, input logic e, input logic [3:0] d,
                       input logic rdy, input logic o, input logic v, input logic l);
        vec_t t;
        t.rst = r; t.dv = dv; t.en = e; t.din = d;
        t.rdy = rdy; t.dout = o; t.vld = v; t.lst = l;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    initial begin
        logic [3:0] rx;
        int         nbits;
        bit         seen_last;

        // Scenario 1: reset held with a word offered; nothing accepted
        for (int i = 0; i < 3; i++) add(1, 1, 1, 4'hF, 1, 0, 0, 0);
        // Scenario 2: single word 1011, MSB first
        add(0, 1, 1, 4'hB, 1, 1, 1, 0);
        add(0, 0, 1, 4'h0, 0, 0, 1, 0);
        add(0, 0, 1, 4'h0, 0, 1, 1, 0);
        add(0, 0, 1, 4'h0, 0, 1, 1, 1);
        add(0, 0, 1, 4'h0, 1, 0, 0, 0);
        // Scenario 3: back-to-back 1011 then 0110 with din_valid held
        add(0, 1, 1, 4'hB, 1, 1, 1, 0);
        add(0, 1, 1, 4'h6, 0, 0, 1, 0);
        add(0, 1, 1, 4'h6, 0, 1, 1, 0);
        add(0, 1, 1, 4'h6, 0, 1, 1, 1);
        add(0, 1, 1, 4'h6, 1, 0, 1, 0);
        add(0, 0, 1, 4'h0, 0, 1, 1, 0);
        add(0, 0, 1, 4'h0, 0, 1, 1, 0);
        add(0, 0, 1, 4'h0, 0, 0, 1, 1);
        add(0, 0, 1, 4'h0, 1, 0, 0, 0);
        // Scenario 4: stall for 2 clocks after the second bit
        add(0, 1, 1, 4'hB, 1, 1, 1, 0);
        add(0, 0, 1, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 1, 4'h0, 0, 1, 1, 0);
        add(0, 0, 1, 4'h0, 0, 1, 1, 1);
        add(0, 0, 1, 4'h0, 1, 0, 0, 0);
        // Scenario 5: reset after two bits, then 1100 cleanly
        add(0, 1, 1, 4'hB, 1, 1, 1, 0);
        add(0, 0, 1, 4'h0, 0, 0, 1, 0);
        add(1, 0, 1, 4'h0, 0, 0, 0, 0);
        add(0, 0, 1, 4'h0, 1, 0, 0, 0);
        add(0, 1, 1, 4'hC, 1, 1, 1, 0);
        add(0, 0, 1, 4'h0, 0, 1, 1, 0);
        add(0, 0, 1, 4'h0, 0, 0, 1, 0);
        add(0, 0, 1, 4'h0, 0, 0, 1, 1);
        add(0, 0, 1, 4'h0, 1, 0, 0, 0);
        // Final bit stalled with a word waiting: not ready until en returns
        add(0, 1, 1, 4'h9, 1, 1, 1, 0);
        add(0, 0, 1, 4'h0, 0, 0, 1, 0);
        add(0, 0, 1, 4'h0, 0, 0, 1, 0);
        add(0, 0, 1, 4'h0, 0, 1, 1, 1);
        add(0, 1, 0, 4'h5, 0, 1, 1, 1);
        add(0, 1, 1, 4'h5, 1, 0, 1, 0);
        add(0, 0, 1, 4'h0, 0, 1, 1, 0);
        add(0, 0, 1, 4'h0, 0, 0, 1, 0);
        add(0, 0, 1, 4'h0, 0, 1, 1, 1);
        add(0, 0, 1, 4'h0, 1, 0, 0, 0);
        // Accept from idle does not need en
        add(0, 1, 0, 4'hA, 1, 1, 1, 0);
        add(0, 0, 1, 4'h0, 0, 0, 1, 0);
        add(0, 0, 1, 4'h0, 0, 1, 1, 0);
        add(0, 0, 1, 4'h0, 0, 0, 1, 1);
        add(0, 0, 1, 4'h0, 1, 0, 0, 0);

        // Bring both instances to a known state before the table.
        rst = 1'b1; din_valid = 1'b0; din = 4'h0; en = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            rst = vecs[i].rst; din_valid = vecs[i].dv; en = vecs[i].en; din = vecs[i].din;
            #1;
            check("din_ready", i, m_ready, vecs[i].rdy);
            @(posedge clk); #1;
            check("dout",       i, m_dout,  vecs[i].dout);
            check("dout_valid", i, m_valid, vecs[i].vld);
            check("last",       i, m_last,  vecs[i].lst);
            check("busy",       i, m_busy,  vecs[i].vld);
        end

        // Scenario 6: LSB-first 1011 -> bits 1,1,0,1, reassembled by a receiver.
        rst = 1'b0; din_valid = 1'b1; din = 4'hB; en = 1'b1;
        #1;
        check("lsb_ready_idle", 0, l_ready, 1'b1);
        rx = 4'h0; nbits = 0; seen_last = 1'b0;
        for (int c = 0; c < 10 && !seen_last; c++) begin
            @(posedge clk); #1;
            din_valid = 1'b0;
            if (l_valid) begin
                rx = {l_dout, rx[3:1]};
                nbits++;
                if (nbits == 1) check("lsb_bit1", c, l_dout, 1'b1);
                if (nbits == 2) check("lsb_bit2", c, l_dout, 1'b1);
                if (nbits == 3) check("lsb_bit3", c, l_dout, 1'b0);
                if (nbits == 4) check("lsb_bit4", c, l_dout, 1'b1);
                check("lsb_last", c, l_last, (nbits == 4) ? 1'b1 : 1'b0);
                if (l_last) seen_last = 1'b1;
            end
        end
        n_checks++;
        if (!seen_last) begin
            n_fail++;
            $display("FAIL lsb_timeout: last not seen within 10 clocks, %0d bits received", nbits);
        end
        n_checks++;
        if (rx !== 4'hB || nbits != 4) begin
            n_fail++;
            $display("FAIL lsb_loopback: got %b (%0d bits) expected 1011 (4 bits)", rx, nbits);
        end
        @(posedge clk); #1;
        check("lsb_idle_valid", 0, l_valid, 1'b0);
        check("lsb_idle_dout",  0, l_dout,  1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
